// File: rtl/axi_slv_mem_if.sv
// Purpose: AXI4 channel bundle (AW/W/B/AR/R) between a master and axi_slv_mem.
// Latency: wiring only, no storage.
// Backpressure: carries the valid/ready pairs; the endpoints own the handshakes.
// Ports (per modport): write address, write data, write response, read address, read data.
interface axi_slv_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
);
    localparam int NB = DATA_W / 8;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [NB-1:0]     wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awid, awaddr, awlen, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_slv_mem.sv
// Purpose: AXI4 slave memory with independent write/read engines, FIXED/INCR/WRAP bursts, error responses.
// Latency: AW->wready next cycle, last W->bvalid next cycle, AR->first R beat next cycle, then 1 beat/cycle.
// Backpressure: one burst outstanding per engine; B and R hold valid and payload until bready/rready.
// Ports: aclk, aresetn (synchronous, active low), bus (axi_slv_mem_if.slave).
// Option: define AXI_SLV_MEM_DECERR_EN to answer DECERR for word indices >= DEPTH (writes dropped, reads 0).
module axi_slv_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 1024
) (
    input  logic          aclk,
    input  logic          aresetn,
    axi_slv_mem_if.slave  bus
);
    localparam int NB     = DATA_W / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int MEM_AW = $clog2(DEPTH);

`ifdef AXI_SLV_MEM_DECERR_EN
    localparam bit DECERR_EN = 1'b1;
`else
    localparam bit DECERR_EN = 1'b0;
`endif

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef logic [IDX_W-1:0] idx_t;

    // Reserved burst code or a WRAP length that is not 2/4/8/16 beats.
    function automatic logic burst_bad(input logic [1:0] burst, input logic [7:0] len);
        return (burst == 2'b11) ||
               ((burst == BURST_WRAP) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    endfunction

    function automatic logic [1:0] burst_eff(input logic [1:0] burst, input logic [7:0] len);
        return burst_bad(burst, len) ? BURST_INCR : burst;
    endfunction

    // Legal WRAP lengths make len a mask of the low index bits that wrap.
    function automatic idx_t idx_next(input idx_t idx, input logic [1:0] burst, input logic [7:0] len);
        idx_t mask;
        mask = idx_t'(len);
        case (burst)
            BURST_FIXED: return idx;
            BURST_WRAP:  return (idx & ~mask) | ((idx + idx_t'(1)) & mask);
            default:     return idx + idx_t'(1);
        endcase
    endfunction

    function automatic logic out_of_range(input idx_t idx);
        return DECERR_EN && ((idx >> MEM_AW) != '0);
    endfunction

    function automatic logic [1:0] resp_enc(input logic dec, input logic slv);
        return dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    // ---------------- write engine ----------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    w_state_t w_state, w_state_nxt;

    logic [ID_W-1:0] w_id;
    idx_t            w_idx;
    logic [7:0]      w_len, w_cnt;
    logic [1:0]      w_burst;
    logic            w_slverr, w_decerr;
    logic            aw_rdy, w_rdy, b_vld;
    logic            aw_hs, w_hs, b_hs;
    idx_t            aw_idx;

    assign aw_idx = idx_t'(bus.awaddr >> OFF_W);

    always_comb begin
        w_state_nxt = w_state;
        aw_rdy      = 1'b0;
        w_rdy       = 1'b0;
        b_vld       = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_rdy = aresetn;
                if (aw_rdy && bus.awvalid) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                w_rdy = aresetn;
                if (w_rdy && bus.wvalid && bus.wlast) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                b_vld = aresetn;
                if (b_vld && bus.bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign aw_hs = aw_rdy && bus.awvalid;
    assign w_hs  = w_rdy && bus.wvalid;
    assign b_hs  = b_vld && bus.bready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state  <= W_IDLE;
            w_id     <= '0;
            w_idx    <= '0;
            w_len    <= '0;
            w_cnt    <= '0;
            w_burst  <= BURST_FIXED;
            w_slverr <= 1'b0;
            w_decerr <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            if (aw_hs) begin
                w_id     <= bus.awid;
                w_idx    <= aw_idx;
                w_len    <= bus.awlen;
                w_cnt    <= '0;
                w_burst  <= burst_eff(bus.awburst, bus.awlen);
                w_slverr <= burst_bad(bus.awburst, bus.awlen);
                w_decerr <= 1'b0;
            end
            if (w_hs) begin
                w_idx <= idx_next(w_idx, w_burst, w_len);
                w_cnt <= w_cnt + 8'd1;
                // Covers both early wlast and a missing wlast on the len-th beat.
                if ((w_cnt == w_len) != bus.wlast) w_slverr <= 1'b1;
                if (out_of_range(w_idx)) w_decerr <= 1'b1;
            end
        end
    end

    // Memory contents survive reset; w_hs is already qualified by aresetn.
    always_ff @(posedge aclk) begin
        if (w_hs && !out_of_range(w_idx)) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.wstrb[b]) mem[w_idx[MEM_AW-1:0]][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    assign bus.awready = aw_rdy;
    assign bus.wready  = w_rdy;
    assign bus.bvalid  = b_vld;
    assign bus.bid     = b_vld ? w_id : '0;
    assign bus.bresp   = b_vld ? resp_enc(w_decerr, w_slverr) : 2'b00;

    // ---------------- read engine ----------------
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    r_state_t r_state, r_state_nxt;

    logic [ID_W-1:0]   r_id;
    idx_t              r_idx, r_nidx, ar_idx, load_idx;
    logic [7:0]        r_len, r_cnt;
    logic [1:0]        r_burst;
    logic              r_slverr, r_last;
    logic              ar_rdy, r_vld, ar_hs, r_hs, load;
    logic [DATA_W-1:0] rdata_q;

    assign ar_idx = idx_t'(bus.araddr >> OFF_W);
    assign r_last = (r_cnt == r_len);

    always_comb begin
        r_state_nxt = r_state;
        ar_rdy      = 1'b0;
        r_vld       = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_rdy = aresetn;
                if (ar_rdy && bus.arvalid) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                r_vld = aresetn;
                if (r_vld && bus.rready && r_last) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    assign ar_hs = ar_rdy && bus.arvalid;
    assign r_hs  = r_vld && bus.rready;

    // rdata_q is prefetched for the beat about to be presented, so a same-edge
    // write to that word is seen only by later loads.
    assign r_nidx   = idx_next(r_idx, r_burst, r_len);
    assign load_idx = ar_hs ? ar_idx : r_nidx;
    assign load     = ar_hs || (r_hs && !r_last);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state  <= R_IDLE;
            r_id     <= '0;
            r_idx    <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_burst  <= BURST_FIXED;
            r_slverr <= 1'b0;
            rdata_q  <= '0;
        end else begin
            r_state <= r_state_nxt;
            if (ar_hs) begin
                r_id     <= bus.arid;
                r_idx    <= ar_idx;
                r_len    <= bus.arlen;
                r_cnt    <= '0;
                r_burst  <= burst_eff(bus.arburst, bus.arlen);
                r_slverr <= burst_bad(bus.arburst, bus.arlen);
            end else if (r_hs && !r_last) begin
                r_idx <= r_nidx;
                r_cnt <= r_cnt + 8'd1;
            end
            if (load) rdata_q <= out_of_range(load_idx) ? '0 : mem[load_idx[MEM_AW-1:0]];
        end
    end

    assign bus.arready = ar_rdy;
    assign bus.rvalid  = r_vld;
    assign bus.rid     = r_vld ? r_id : '0;
    assign bus.rdata   = r_vld ? rdata_q : '0;
    assign bus.rlast   = r_vld && r_last;
    // Decode errors are per beat; SLVERR from a bad burst type covers every beat.
    assign bus.rresp   = r_vld ? resp_enc(out_of_range(r_idx), r_slverr) : 2'b00;
endmodule

// File: doc/axi_slv_mem.md
# axi_slv_mem

Synthesisable AXI4 slave memory: the RTL responder that the AxiVip master agent drives in place of the behavioural slave agent, so a full master/slave path runs in a single simulation. It supersedes the fixed-geometry behavioural slave with these new capabilities:
- parametrised data, address and ID widths and memory depth;
- independent read and write engines;
- FIXED, INCR and WRAP bursts;
- protocol-error responses.

## Interface
- DATA_W, 32, data bus width in bits, power of 2, ≥8; bytes per beat NB = DATA_W/8
- ADDR_W, 32, byte address width
- ID_W, 4, transaction ID width
- DEPTH, 1024, memory depth in DATA_W words, power of 2
- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  synchronous active-low reset
- awid  in  ID_W  write ID
- awaddr  in  ADDR_W  write start byte address
- awlen  in  8  beats−1
- awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
- awvalid / awready  in / out  1  AW handshake
- wdata  in  DATA_W  write data
- wstrb  in  NB  byte enables
- wlast  in  1  last write beat
- wvalid / wready  in / out  1  W handshake
- bid  out  ID_W  echoed awid
- bresp  out  2  write response
- bvalid / bready  out / in  1  B handshake
- arid  in  ID_W  read ID
- araddr  in  ADDR_W  read start byte address
- arlen  in  8  beats−1
- arburst  in  2  burst type
- arvalid / arready  in / out  1  AR handshake
- rid  out  ID_W  echoed arid
- rdata  out  DATA_W  read data
- rresp  out  2  read response
- rlast  out  1  last read beat
- rvalid / rready  out / in  1  R handshake

## Operation
- **Beat size.** Always NB bytes; there is no AxSIZE port.
- **Word index.** awaddr/araddr[ADDR_W−1:log2(NB)]; the low byte-offset bits are ignored. The memory location is index mod DEPTH.
- **Write FSM, W_IDLE.** awready=1. AW handshake latches id, index, len, burst; clears beat count and error flags; goes to W_DATA.
- **Write FSM, W_DATA.** wready=1. Each W handshake writes the bytes enabled by wstrb, then advances the index. A handshake with wlast=1 goes to W_RESP.
- **Write FSM, W_RESP.** bvalid=1. A B handshake returns to W_IDLE.
- **Read FSM, R_IDLE.** arready=1. AR handshake latches the same fields and goes to R_DATA.
- **Read FSM, R_DATA.** rvalid=1. rlast=1 when beat count == len. An R handshake advances the index. An R handshake with rlast returns to R_IDLE.
- **Engine independence.** Read and write engines share only the memory array. Each engine holds one outstanding burst.
- **Index advance.**
  - FIXED: index unchanged.
  - INCR: index+1.
  - WRAP: the low log2(len+1) bits increment modulo len+1 and the upper bits are held.
- **Legal WRAP.** WRAP is legal only for len ∈ {1,3,7,15}. An illegal WRAP, or burst=11, is executed as INCR and flags SLVERR.
- **Beat-count mismatch.** Applies when wlast arrives on beat ≠ len, or len is reached without wlast. The burst always ends at wlast, and SLVERR is flagged.
- **Response encoding.** OKAY=00, SLVERR=10, DECERR=11. DECERR has priority over SLVERR. bresp and rresp report the accumulated flag for their burst; rresp is per beat.
- **Read data stability.** rdata comes from a register loaded from mem[next index] at the AR handshake and at each non-last R handshake. It is stable while rvalid=1 and rready=0.

## Timing
- **Reset values.** In any cycle with aresetn=0, all outputs are 0 and both FSMs go to IDLE. awready/arready are 1 in the first cycle after aresetn rises.
- **Reset mid-burst.** Reset during a burst drops that burst with no B/R response. Memory contents are not reset.
- **Write latency.** AW handshake in cycle N → wready=1 from N+1. Last W handshake in cycle M → bvalid=1 in M+1. awready=0 from N+1 until the cycle after the B handshake.
- **Read latency.** AR handshake in cycle N → rvalid=1 with the first beat in N+1. Thereafter one beat per cycle while rready=1.
- **Read/write collision.** A write and a read-data load to the same word in the same cycle return the old data; the write takes effect at that edge.
- **Handshake rule.** No ready depends combinationally on the matching valid. valid outputs stay high until accepted.

## Configuration
- **AXI_SLV_MEM_DECERR_EN defined.**
  - Any beat whose index ≥ DEPTH flags DECERR.
  - Writes on such beats are suppressed.
  - Reads on such beats return rdata=0.
  - Other beats of the same burst are unaffected.
- **AXI_SLV_MEM_DECERR_EN undefined.** The index wraps mod DEPTH with no DECERR; only SLVERR/OKAY are produced.

## Test plan
- **INCR write/read.** Write INCR awaddr=0x100, awlen=3, data 0xA0..0xA3, wstrb=F → bresp=00, bid=awid. Then read araddr=0x100, arlen=3 → rdata A0,A1,A2,A3, rlast on beat 3 only, rresp=00.
- **WRAP.** WRAP awaddr=0x38, awlen=3 (NB=4) → words 0x0E,0x0F,0x0C,0x0D written. A WRAP read from 0x38 returns them in the same order.
- **Strobes and FIXED.** FIXED write to 0x10 of 0x11111111 (wstrb=F) then 0x2222 (wstrb=3), awlen=1 → read 0x10 returns 0x11112222.
- **Errors.** awlen=2 with wlast on beat 1 → bresp=10. WRAP with arlen=2 → INCR order, rresp=10.
- **Decode error.** With the macro defined, read word index 1024 (DEPTH=1024) → rresp=11, rdata=0, and word 0 unchanged. Without the macro, the same read returns word 0 with rresp=00.
- **Backpressure, collision and reset.**
  - Hold rready=0 for 5 cycles mid-burst → rdata/rlast stable.
  - Overlap an unrelated write to the word being presented → old data still returned.
  - Assert aresetn=0 mid-burst → all outputs 0 next cycle; awready=1 one cycle after release.
